// File: rtl/fifo_wr_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// fifo_wr_arbiter : round-robin burst arbiter for a shared FIFO write port
// Rev 1.0
// ---------------------------------------------------------------------------
module fifo_wr_arbiter #(
  parameter int data_size = 8,
  parameter int NUM_REQ   = 4,
  parameter int BURST_LEN = 4
) (
  input  logic                         wr_clk,
  input  logic                         wr_rst_n,
  input  logic [NUM_REQ-1:0]           req,
  input  logic [NUM_REQ*data_size-1:0] req_data,
  input  logic                         full,
  output logic [NUM_REQ-1:0]           ack,
  output logic [NUM_REQ-1:0]           grant,
  output logic                         wr_inc,
  output logic [data_size-1:0]         data_in,
  output logic                         busy,
  output logic [15:0]                  wr_count
);

  localparam int PTR_W  = $clog2(NUM_REQ);
  localparam int BEAT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BURST_LEN - 1);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

  state_t              state_q, state_d;
  logic [PTR_W-1:0]    rr_ptr_q, rr_ptr_d;
  logic [PTR_W-1:0]    owner_q, owner_d;
  logic [BEAT_W-1:0]   beat_cnt_q, beat_cnt_d;
  logic [NUM_REQ-1:0]  grant_q, grant_d;
  logic                busy_q, busy_d;
  logic [15:0]         wr_count_q, wr_count_d;

  logic [2*NUM_REQ-1:0] req_dbl;
  logic [PTR_W:0]       rot_base;
  logic [NUM_REQ-1:0]   req_rot;
  logic [PTR_W-1:0]     rot_off;
  logic [PTR_W-1:0]     sel_idx;
  logic [PTR_W-1:0]     next_ptr;
  logic                 owner_req;

  // Rotate requests so bit 0 is rr_ptr; the lowest set bit is then the winner.
  assign req_dbl  = {req, req};
  assign rot_base = {1'b0, rr_ptr_q};
  assign req_rot  = req_dbl[rot_base +: NUM_REQ];

  always_comb begin
    rot_off = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req_rot[i]) rot_off = PTR_W'(i);
    end
  end

  assign sel_idx  = PTR_W'((32'(rr_ptr_q) + 32'(rot_off)) % NUM_REQ);
  assign next_ptr = PTR_W'((32'(owner_q) + 32'd1) % NUM_REQ);

  assign owner_req = req[owner_q];
  assign wr_inc    = (state_q == BURST) && owner_req && !full;

  always_comb begin
    ack     = '0;
    data_in = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (owner_q == PTR_W'(i)) begin
        ack[i] = wr_inc;
        if (state_q == BURST) data_in = req_data[i*data_size +: data_size];
      end
    end
  end

  assign grant    = grant_q;
  assign busy     = busy_q;
  assign wr_count = wr_count_q;

  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    owner_d    = owner_q;
    beat_cnt_d = beat_cnt_q;
    grant_d    = grant_q;
    busy_d     = busy_q;
    wr_count_d = wr_count_q + {15'd0, wr_inc};

    case (state_q)
      IDLE: begin
        if (|req) begin
          owner_d    = sel_idx;
          grant_d    = {{(NUM_REQ-1){1'b0}}, 1'b1} << sel_idx;
          beat_cnt_d = '0;
          busy_d     = 1'b1;
          state_d    = BURST;
        end
      end
      BURST: begin
        // A full-flag stall falls through both branches and holds everything.
        if (wr_inc && (beat_cnt_q != LAST_BEAT)) begin
          beat_cnt_d = beat_cnt_q + BEAT_W'(1);
        end else if (wr_inc || !owner_req) begin
          state_d  = IDLE;
          grant_d  = '0;
          busy_d   = 1'b0;
          rr_ptr_d = next_ptr;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge wr_clk or negedge wr_rst_n) begin
    if (!wr_rst_n) begin
      state_q    <= IDLE;
      rr_ptr_q   <= '0;
      owner_q    <= '0;
      beat_cnt_q <= '0;
      grant_q    <= '0;
      busy_q     <= 1'b0;
      wr_count_q <= '0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      owner_q    <= owner_d;
      beat_cnt_q <= beat_cnt_d;
      grant_q    <= grant_d;
      busy_q     <= busy_d;
      wr_count_q <= wr_count_d;
    end
  end

endmodule
`default_nettype wire
